wb_stage: RTL and testbench



---
 rtl/riscv_pkg.sv | 30 +++
 rtl/load_align.sv | 34 +++
 rtl/wb_stage.sv | 158 +++++++++++++++
 tb/tb_wb_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the writeback stage: load/writeback select codes,
// the writeback FSM state type and the writeback source mux helper.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] LD_LB   = 3'h0;
    localparam logic [2:0] LD_LH   = 3'h1;
    localparam logic [2:0] LD_LW   = 3'h2;
    localparam logic [2:0] LD_LBU  = 3'h3;
    localparam logic [2:0] LD_LHU  = 3'h4;
    localparam logic [2:0] LD_NONE = 3'h7;

    localparam logic [1:0] WB_MEM = 2'h0;
    localparam logic [1:0] WB_ALU = 2'h1;
    localparam logic [1:0] WB_PC4 = 2'h2;

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } wb_state_t;

    // Non-memory writeback source; reserved code 3 falls back to the ALU result.
    function automatic logic [XLEN-1:0] wb_select(input logic [1:0]      sel,
                                                  input logic [XLEN-1:0] alu,
                                                  input logic [XLEN-1:0] pc);
        return (sel == WB_PC4) ? pc + 32'd4 : alu;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the word-aligned
// memory response and sign- or zero-extends it according to the load type.
module load_align
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] rsp_data,
    input  logic [1:0]      offset,
    input  logic [2:0]      ld_sel,
    output logic [XLEN-1:0] ld_val
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (offset)
            2'd0:    byte_v = rsp_data[7:0];
            2'd1:    byte_v = rsp_data[15:8];
            2'd2:    byte_v = rsp_data[23:16];
            default: byte_v = rsp_data[31:24];
        endcase
        // Halfword ignores offset[0]; misaligned halves are not trapped.
        half_v = offset[1] ? rsp_data[31:16] : rsp_data[15:0];

        case (ld_sel)
            LD_LB:   ld_val = {{24{byte_v[7]}}, byte_v};
            LD_LH:   ld_val = {{16{half_v[15]}}, half_v};
            LD_LBU:  ld_val = {24'h0, byte_v};
            LD_LHU:  ld_val = {16'h0, half_v};
            default: ld_val = rsp_data;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: selects the write source, stalls while a load response is
// outstanding and drives the register-file write port. Bypass outputs: WB_BYPASS_EN.
module wb_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] alu,
    input  logic [2:0]      LDSel,
    input  logic [1:0]      WBSel,
    input  logic            RegWen,
    input  logic [31:0]     inst,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            byp_valid,
    output logic [4:0]      byp_addr,
    output logic [XLEN-1:0] byp_data
);

    wb_state_t       state_q, state_d;
    logic [4:0]      rd_q, rd_d;
    logic            regwen_q, regwen_d;
    logic [1:0]      off_q, off_d;
    logic [2:0]      ldsel_q, ldsel_d;
    logic            mem_src_q, mem_src_d;
    logic [XLEN-1:0] alt_q, alt_d;
    logic            pend_vld_q, pend_vld_d;
    logic [4:0]      pend_addr_q, pend_addr_d;
    logic [XLEN-1:0] pend_data_q, pend_data_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    logic [XLEN-1:0] ld_val;
    logic            accept, is_load, complete, new_we, done_we;
    logic [XLEN-1:0] new_data, done_data;
    logic            unused_inst;

    assign unused_inst = ^{inst[31:12], inst[6:0]};

    load_align u_load_align (
        .rsp_data (rsp_data),
        .offset   (off_q),
        .ld_sel   (ldsel_q),
        .ld_val   (ld_val)
    );

    always_comb begin
        in_ready  = (state_q == IDLE) || rsp_valid;
        accept    = in_valid && in_ready;
        is_load   = (LDSel != LD_NONE);
        complete  = (state_q == WAIT_MEM) && rsp_valid;
        new_we    = accept && !is_load && RegWen && (inst[11:7] != 5'd0);
        new_data  = wb_select(WBSel, alu, pc);
        done_we   = complete && regwen_q && (rd_q != 5'd0);
        done_data = mem_src_q ? ld_val : alt_q;

        state_d     = state_q;
        rd_d        = rd_q;
        regwen_d    = regwen_q;
        off_d       = off_q;
        ldsel_d     = ldsel_q;
        mem_src_d   = mem_src_q;
        alt_d       = alt_q;
        pend_vld_d  = 1'b0;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;

        if (accept && is_load) begin
            state_d   = WAIT_MEM;
            rd_d      = inst[11:7];
            regwen_d  = RegWen;
            off_d     = alu[1:0];
            ldsel_d   = LDSel;
            mem_src_d = (WBSel == WB_MEM);
            alt_d     = wb_select(WBSel, alu, pc);
        end else if (complete) begin
            state_d = IDLE;
        end

        // One write port: older results go first, a displaced non-load waits one cycle.
        if (done_we) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = rd_q;
            rf_wdata_d = done_data;
        end else if (pend_vld_q) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = pend_addr_q;
            rf_wdata_d = pend_data_q;
        end else if (new_we) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = inst[11:7];
            rf_wdata_d = new_data;
        end

        if (new_we && (done_we || pend_vld_q)) begin
            pend_vld_d  = 1'b1;
            pend_addr_d = inst[11:7];
            pend_data_d = new_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_q        <= '0;
            regwen_q    <= 1'b0;
            off_q       <= '0;
            ldsel_q     <= LD_NONE;
            mem_src_q   <= 1'b0;
            alt_q       <= '0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            regwen_q    <= regwen_d;
            off_q       <= off_d;
            ldsel_q     <= ldsel_d;
            mem_src_q   <= mem_src_d;
            alt_q       <= alt_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

`ifdef WB_BYPASS_EN
    assign byp_valid = rf_we_q;
    assign byp_addr  = rf_waddr_q;
    assign byp_data  = rf_wdata_q;
`else
    assign byp_valid = 1'b0;
    assign byp_addr  = '0;
    assign byp_data  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed test-plan steps followed by random traffic, checked
// against an in-order queue model of register-file writes.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] pc, alu, inst, rsp_data;
    logic [2:0]  LDSel;
    logic [1:0]  WBSel;
    logic        RegWen, rsp_valid;
    logic        rf_we, byp_valid;
    logic [4:0]  rf_waddr, byp_addr;
    logic [31:0] rf_wdata, byp_data;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .alu(alu), .LDSel(LDSel), .WBSel(WBSel), .RegWen(RegWen),
        .inst(inst), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    // Reference model: writes retire in program order, one per cycle.
    wr_t         expq[$];
    logic [4:0]  last_a;
    logic [31:0] last_d;
    bit          waiting;
    logic [4:0]  p_rd;
    bit          p_we;
    logic [1:0]  p_wb;
    logic [2:0]  p_ld;
    logic [31:0] p_alu, p_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_value(input logic [31:0] w, input logic [1:0] a,
                                              input logic [2:0] ld);
        logic [31:0] byt;
        logic [31:0] half;
        byt  = (w >> (8 * a)) & 32'hFF;
        half = (w >> (16 * a[1])) & 32'hFFFF;
        case (ld)
            3'd0:    return (byt >= 32'd128) ? byt + 32'hFFFF_FF00 : byt;
            3'd1:    return (half >= 32'd32768) ? half + 32'hFFFF_0000 : half;
            3'd3:    return byt;
            3'd4:    return half;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] src(input logic [1:0] wb, input logic [31:0] a,
                                        input logic [31:0] p, input logic [31:0] memv);
        if (wb == 2'd0) return memv;
        if (wb == 2'd2) return p + 32'd4;
        return a;
    endfunction

    task automatic check_outputs(input bit exp_we);
        chk("rf_we", 32'(rf_we), 32'(exp_we));
        chk("rf_waddr", 32'(rf_waddr), 32'(last_a));
        chk("rf_wdata", rf_wdata, last_d);
`ifdef WB_BYPASS_EN
        chk("byp_valid", 32'(byp_valid), 32'(exp_we));
        chk("byp_addr", 32'(byp_addr), 32'(last_a));
        chk("byp_data", byp_data, last_d);
`else
        chk("byp_zero", {byp_data[31:6], byp_valid, byp_addr}, 32'h0);
`endif
    endtask

    task automatic cycle(input logic iv, input logic [2:0] ld, input logic [1:0] wb,
                         input logic rw, input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] p, input logic rv, input logic [31:0] rdat);
        logic [31:0] t;
        bit          exp_rdy;
        bit          exp_we;
        wr_t         w;
        t        = $urandom;
        t[11:7]  = rd;
        in_valid = iv; LDSel = ld; WBSel = wb; RegWen = rw; inst = t;
        alu = a; pc = p; rsp_valid = rv; rsp_data = rdat;
        @(negedge clk);
        exp_rdy = !waiting || rv;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (waiting && rv) begin
            if (p_we && p_rd != 5'd0)
                expq.push_back('{p_rd, src(p_wb, p_alu, p_pc, mem_value(rdat, p_alu[1:0], p_ld))});
            waiting = 0;
        end
        if (iv && exp_rdy) begin
            if (ld != 3'd7) begin
                waiting = 1; p_rd = rd; p_we = rw; p_wb = wb; p_ld = ld; p_alu = a; p_pc = p;
            end else if (rw && rd != 5'd0) begin
                expq.push_back('{rd, src(wb, a, p, 32'h0)});
            end
        end
        @(posedge clk);
        #1;
        exp_we = 0;
        if (expq.size() > 0) begin
            w = expq.pop_front();
            last_a = w.a; last_d = w.d; exp_we = 1;
        end
        check_outputs(exp_we);
    endtask

    task automatic idle(input logic rv, input logic [31:0] rdat);
        cycle(1'b0, 3'd7, 2'd1, 1'b0, 5'd0, 32'h0, 32'h0, rv, rdat);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        waiting = 0; expq.delete(); last_a = '0; last_d = '0;
        check_outputs(1'b0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 0; LDSel = 3'd7; WBSel = 2'd1; RegWen = 0;
        inst = 0; alu = 0; pc = 0; rsp_valid = 0; rsp_data = 0;
        waiting = 0; last_a = '0; last_d = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs(1'b0);
        rst_n = 1'b1;

        // Non-load ALU write, then a quiet cycle.
        cycle(1, 3'd7, 2'd1, 1, 5'd5, 32'h1837, 32'h1223_2334, 0, 32'h0);
        chk("alu_wdata", rf_wdata, 32'h0000_1837);
        chk("alu_waddr", 32'(rf_waddr), 32'd5);
        idle(0, 32'h0);

        // JAL with pc+4 wrapping past 2^32.
        cycle(1, 3'd7, 2'd2, 1, 5'd1, 32'h55, 32'hFFFF_FFFC, 0, 32'h0);
        chk("jal_wdata", rf_wdata, 32'h0);

        // LB with a three-cycle memory response.
        cycle(1, 3'd0, 2'd0, 1, 5'd7, 32'h1003, 32'h400, 0, 32'h0);
        idle(0, 32'h0);
        idle(0, 32'h0);
        idle(1, 32'h80AA_BBCC);
        chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);

        // LHU, then LBU accepted in the LHU completion cycle.
        cycle(1, 3'd4, 2'd0, 1, 5'd8, 32'h2002, 32'h500, 0, 32'h0);
        cycle(1, 3'd3, 2'd0, 1, 5'd9, 32'h2001, 32'h504, 1, 32'h9876_1234);
        chk("lhu_wdata", rf_wdata, 32'h0000_9876);
        idle(1, 32'h9876_1234);
        chk("lbu_wdata", rf_wdata, 32'h0000_0012);

        // Load completion colliding with a following non-load, then back-to-back ALU ops.
        cycle(1, 3'd2, 2'd0, 1, 5'd10, 32'h3000, 32'h600, 0, 32'h0);
        cycle(1, 3'd7, 2'd1, 1, 5'd11, 32'hAAAA, 32'h604, 1, 32'hCAFE_F00D);
        cycle(1, 3'd7, 2'd1, 1, 5'd12, 32'hBBBB, 32'h608, 0, 32'h0);
        idle(0, 32'h0);
        idle(0, 32'h0);

        // x0 and RegWen=0 produce no writes.
        cycle(1, 3'd7, 2'd1, 1, 5'd0, 32'h1234, 32'h700, 0, 32'h0);
        cycle(1, 3'd7, 2'd1, 0, 5'd3, 32'h5678, 32'h704, 0, 32'h0);
        idle(0, 32'h0);

        // Reset while a load is outstanding; the late response must be ignored.
        cycle(1, 3'd2, 2'd0, 1, 5'd13, 32'h4000, 32'h800, 0, 32'h0);
        idle(0, 32'h0);
        do_reset();
        idle(1, 32'hDEAD_BEEF);
        idle(0, 32'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  ld;
            logic [1:0]  wb;
            logic [31:0] p;
            ld = 3'($urandom_range(0, 11) > 7 ? 7 : $urandom_range(0, 7));
            wb = (ld == 3'd7) ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
            p  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
            if (i == 200) do_reset();
            cycle(1'($urandom_range(0, 3) != 0), ld, wb, 1'($urandom_range(0, 4) != 0),
                  5'($urandom_range(0, 31)), $urandom, p,
                  1'($urandom_range(0, 2) != 0), $urandom);
        end
        idle(1, 32'h0);
        repeat (3) idle(0, 32'h0);
        chk("drain", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
